// File: rtl/mux_scan_sequencer.sv
// Select sequencer for a 4:1 bit mux: steps through enabled channels, dwells,
// captures each mux bit, then hands the assembled 4-bit snapshot downstream.
//
//   state  | meaning
//   IDLE   | waiting for start with a non-empty channel mask
//   SETTLE | sel held for DWELL cycles, then mux bit captured
//   DONE   | snapshot valid, waiting for ready
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] chan_en,
    input  logic       z_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] sample,
    output logic       valid,
    input  logic       ready
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state, state_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       sample_nxt;
    logic [3:0]       mask, mask_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       higher;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Enabled channels strictly above the one currently selected.
    assign higher = mask & (4'b1110 << sel);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sel    <= 2'd0;
            sample <= 4'd0;
            mask   <= 4'd0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            sample <= sample_nxt;
            mask   <= mask_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        sample_nxt = sample;
        mask_nxt   = mask;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (start && (chan_en != 4'd0)) begin
                    mask_nxt   = chan_en;
                    sample_nxt = 4'd0;
                    cnt_nxt    = '0;
                    sel_nxt    = lowest(chan_en);
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    sample_nxt[sel] = z_in;
                    cnt_nxt         = '0;
                    if (higher != 4'd0) sel_nxt = lowest(higher);
                    else                state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DWELL=4 and DWELL=1) checked every
// cycle against an edge-count model, plus directed literal expectations.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_v   [2];
    logic [3:0] chan_en_v [2];
    logic       ready_v   [2];
    logic [3:0] x_v       [2];
    logic       z_v       [2];
    logic [1:0] sel_v     [2];
    logic       busy_v    [2];
    logic [3:0] sample_v  [2];
    logic       valid_v   [2];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign z_v[0] = x_v[0][sel_v[0]];
    assign z_v[1] = x_v[1][sel_v[1]];

    mux_scan_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .chan_en(chan_en_v[0]),
        .z_in(z_v[0]), .sel(sel_v[0]), .busy(busy_v[0]), .sample(sample_v[0]),
        .valid(valid_v[0]), .ready(ready_v[0])
    );

    mux_scan_sequencer #(.DWELL(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .chan_en(chan_en_v[1]),
        .z_in(z_v[1]), .sel(sel_v[1]), .busy(busy_v[1]), .sample(sample_v[1]),
        .valid(valid_v[1]), .ready(ready_v[1])
    );

    // Reference model: a scan is a list of enabled channels; edge k after the
    // start edge captures channel k/DWELL-1 whenever k is a multiple of DWELL.
    int         m_k      [2];
    int         m_n      [2];
    int         m_chan   [2][4];
    bit         m_busy   [2];
    bit         m_valid  [2];
    logic [1:0] m_sel    [2];
    logic [3:0] m_sample [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_k[u] = 0; m_n[u] = 0; m_busy[u] = 0; m_valid[u] = 0;
            m_sel[u] = 2'd0; m_sample[u] = 4'd0;
        end
    endtask

    task automatic model_step(input int u);
        int d;
        int ci;
        d = (u == 0) ? 4 : 1;
        if (!m_busy[u]) begin
            if (start_v[u] && chan_en_v[u] != 4'd0) begin
                m_n[u] = 0;
                for (int c = 0; c < 4; c++)
                    if (chan_en_v[u][c]) begin
                        m_chan[u][m_n[u]] = c;
                        m_n[u]++;
                    end
                m_k[u] = 0;
                m_sel[u] = 2'(m_chan[u][0]);
                m_sample[u] = 4'd0;
                m_busy[u] = 1;
            end
        end else if (m_valid[u]) begin
            if (ready_v[u]) begin
                m_valid[u] = 0;
                m_busy[u] = 0;
            end
        end else begin
            m_k[u]++;
            if (m_k[u] % d == 0) begin
                ci = m_k[u] / d - 1;
                m_sample[u][m_chan[u][ci]] = x_v[u][m_sel[u]];
                if (ci + 1 < m_n[u]) m_sel[u] = 2'(m_chan[u][ci + 1]);
                else                 m_valid[u] = 1;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_sel", u),    32'(sel_v[u]),    32'(m_sel[u]));
            check($sformatf("u%0d_busy", u),   32'(busy_v[u]),   32'(m_busy[u]));
            check($sformatf("u%0d_valid", u),  32'(valid_v[u]),  32'(m_valid[u]));
            check($sformatf("u%0d_sample", u), 32'(sample_v[u]), 32'(m_sample[u]));
        end
    end

    task automatic start_scan(input int u, input logic [3:0] mask);
        start_v[u] = 1'b1;
        chan_en_v[u] = mask;
        @(negedge clk);
        start_v[u] = 1'b0;
    endtask

    task automatic wait_valid(input int u, input int n0, output int n, output logic [3:0] seen);
        n = n0;
        seen = 4'd0;
        while (!valid_v[u] && n < 100) begin
            seen[sel_v[u]] = 1'b1;
            @(negedge clk);
            n++;
        end
        seen[sel_v[u]] = 1'b1;
        check("valid_seen", 32'(valid_v[u]), 32'd1);
    endtask

    int         n;
    logic [3:0] seen;

    initial begin
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 0; chan_en_v[u] = 0; ready_v[u] = 0; x_v[u] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel_v[0]), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_valid", 32'(valid_v[0]), 32'd0);
        check("rst_sample", 32'(sample_v[0]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // start with an empty mask is ignored
        start_scan(0, 4'b0000);
        check("empty_busy", 32'(busy_v[0]), 32'd0);
        check("empty_sel", 32'(sel_v[0]), 32'd0);

        // full scan, mux data 1010
        ready_v[0] = 1; x_v[0] = 4'b1010;
        start_scan(0, 4'b1111);
        wait_valid(0, 0, n, seen);
        check("full_vedge", 32'(n), 32'd16);
        check("full_sample", 32'(sample_v[0]), 32'b1010);
        check("full_seen", 32'(seen), 32'b1111);
        @(negedge clk);
        check("full_pulse", 32'(valid_v[0]), 32'd0);
        check("full_busy_drop", 32'(busy_v[0]), 32'd0);

        // sparse mask
        x_v[0] = 4'b1111;
        start_scan(0, 4'b1010);
        wait_valid(0, 0, n, seen);
        check("sparse_vedge", 32'(n), 32'd8);
        check("sparse_sample", 32'(sample_v[0]), 32'b1010);
        check("sparse_seen", 32'(seen), 32'b1010);
        @(negedge clk);

        // start and mask change mid-scan are ignored
        x_v[0] = 4'b0110;
        start_scan(0, 4'b1111);
        repeat (5) @(negedge clk);
        start_v[0] = 1; chan_en_v[0] = 4'b0001;
        @(negedge clk);
        start_v[0] = 0;
        wait_valid(0, 6, n, seen);
        check("midstart_vedge", 32'(n), 32'd16);
        check("midstart_sample", 32'(sample_v[0]), 32'b0110);
        @(negedge clk);

        // backpressure
        ready_v[0] = 0; x_v[0] = 4'b1010;
        start_scan(0, 4'b1111);
        wait_valid(0, 0, n, seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(valid_v[0]), 32'd1);
            check("bp_sample", 32'(sample_v[0]), 32'b1010);
            check("bp_sel", 32'(sel_v[0]), 32'd3);
        end
        ready_v[0] = 1;
        @(negedge clk);
        check("bp_valid_drop", 32'(valid_v[0]), 32'd0);
        check("bp_busy_drop", 32'(busy_v[0]), 32'd0);
        check("bp_sel_kept", 32'(sel_v[0]), 32'd3);
        check("bp_sample_kept", 32'(sample_v[0]), 32'b1010);

        // start together with ready in DONE only returns to IDLE
        ready_v[0] = 0; x_v[0] = 4'b0100;
        start_scan(0, 4'b0100);
        wait_valid(0, 0, n, seen);
        check("one_vedge", 32'(n), 32'd4);
        ready_v[0] = 1; start_v[0] = 1; chan_en_v[0] = 4'b1111;
        @(negedge clk);
        start_v[0] = 0;
        check("done_start_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("done_start_busy2", 32'(busy_v[0]), 32'd0);
        check("done_start_sample", 32'(sample_v[0]), 32'b0100);

        // DWELL=1 instance
        ready_v[1] = 1; x_v[1] = 4'b0001;
        start_scan(1, 4'b0001);
        check("d1_sel", 32'(sel_v[1]), 32'd0);
        check("d1_busy", 32'(busy_v[1]), 32'd1);
        wait_valid(1, 0, n, seen);
        check("d1_vedge", 32'(n), 32'd1);
        check("d1_sample", 32'(sample_v[1]), 32'b0001);
        @(negedge clk);
        x_v[1] = 4'b1001;
        start_scan(1, 4'b1011);
        wait_valid(1, 0, n, seen);
        check("d1b_vedge", 32'(n), 32'd3);
        check("d1b_sample", 32'(sample_v[1]), 32'b1001);
        @(negedge clk);

        // reset mid-scan, asserted between edges
        ready_v[0] = 1; x_v[0] = 4'b1111;
        start_scan(0, 4'b1111);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mrst_sel", 32'(sel_v[0]), 32'd0);
        check("mrst_valid", 32'(valid_v[0]), 32'd0);
        check("mrst_busy", 32'(busy_v[0]), 32'd0);
        check("mrst_sample", 32'(sample_v[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        x_v[0] = 4'b0101;
        start_scan(0, 4'b1111);
        wait_valid(0, 0, n, seen);
        check("post_rst_vedge", 32'(n), 32'd16);
        check("post_rst_sample", 32'(sample_v[0]), 32'b0101);
        @(negedge clk);

        // randomized traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            for (int u = 0; u < 2; u++) begin
                start_v[u]   = ($urandom_range(0, 3) == 0);
                chan_en_v[u] = 4'($urandom_range(0, 15));
                ready_v[u]   = ($urandom_range(0, 2) != 0);
                x_v[u]       = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
